// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined CLA adder/subtractor.
//   SEG_W   : bits handled per pipeline stage
//   GRP_W   : bits per first-level lookahead group
//   flags_t : packed {N,Z,V,C} status word, N in bit 3
package cla_pkg;

    localparam int SEG_W = 16;
    localparam int GRP_W = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

endpackage

// File: rtl/cla_pipe_addsub_if.sv
// Operand/result stream bundle for cla_pipe_addsub.
//   in_valid/in_ready   : operand handshake
//   in_a/in_b           : operands
//   in_sub/in_sat       : per-beat mode (subtract, saturate)
//   out_valid/out_ready : result handshake
//   out_sum/out_flags   : result and {N,Z,V,C}
// master = producer/consumer side, slave = the adder.
interface cla_pipe_addsub_if
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    flags_t           out_flags;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_sat, out_ready,
        input  in_ready, out_valid, out_sum, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_sat, out_ready,
        output in_ready, out_valid, out_sum, out_flags
    );
endinterface

// File: rtl/cla_lookahead4.sv
// 4-bit carry-lookahead unit. Used both on raw bit generate/propagate
// and, one level up, on group generate/propagate.
//   i_g, i_p : generate/propagate of the four inputs
//   i_cin    : carry into position 0
//   o_c      : carries into positions 1..3
//   o_gg     : group generate, o_pp : group propagate (independent of i_cin)
module cla_lookahead4 (
    input  logic [3:0] i_g,
    input  logic [3:0] i_p,
    input  logic       i_cin,
    output logic [3:1] o_c,
    output logic       o_gg,
    output logic       o_pp
);
    assign o_c[1] = i_g[0] | (i_p[0] & i_cin);
    assign o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_cin);
    assign o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                  | (i_p[2] & i_p[1] & i_p[0] & i_cin);

    assign o_gg = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
                | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
    assign o_pp = &i_p;
endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor, one 16-bit segment per stage.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : cla_pipe_addsub_if.slave (operand and result streams)
// Latency WIDTH/16 cycles, one beat per cycle when the output is drained.
// Operands travel with the beat so each stage sees its own segment; the
// partial result accumulates segment by segment so all bits arrive together.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit SAT_EN = 1'b1
)(
    input  logic              clk,
    input  logic              rst,
    cla_pipe_addsub_if.slave  bus
);
    localparam int NSEG = WIDTH / SEG_W;
    localparam int NGRP = SEG_W / GRP_W;
    localparam logic [WIDTH-1:0] SEG_ONES = WIDTH'({SEG_W{1'b1}});

    logic             w_adv;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    flags_t           r_out_flags;

    // Inputs seen by stage k; w_b already holds B' (inverted when subtracting).
    logic             w_vld  [NSEG];
    logic             w_sat  [NSEG];
    logic             w_cin  [NSEG];
    logic [WIDTH-1:0] w_a    [NSEG];
    logic [WIDTH-1:0] w_b    [NSEG];
    logic [WIDTH-1:0] w_lo   [NSEG];
    // Outputs of stage k: partial result with segment k filled in, carry-out.
    logic [WIDTH-1:0] w_res  [NSEG];
    logic             w_cout [NSEG];

    assign w_adv        = !r_out_valid | bus.out_ready;
    assign bus.in_ready = w_adv;

    assign w_vld[0] = bus.in_valid;
    assign w_sat[0] = bus.in_sat & SAT_EN;
    assign w_cin[0] = bus.in_sub;
    assign w_a[0]   = bus.in_a;
    assign w_b[0]   = bus.in_b ^ {WIDTH{bus.in_sub}};
    assign w_lo[0]  = '0;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        logic [SEG_W-1:0] w_sa, w_sb, w_g, w_p, w_cv, w_sum;
        logic [NGRP-1:0]  w_gg, w_pp, w_gc;
        logic [3:1]       w_gc_hi;
        logic             w_seg_g, w_seg_p;

        assign w_sa = w_a[k][k*SEG_W +: SEG_W];
        assign w_sb = w_b[k][k*SEG_W +: SEG_W];
        assign w_g  = w_sa & w_sb;
        assign w_p  = w_sa ^ w_sb;

        for (genvar j = 0; j < NGRP; j++) begin : g_grp
            logic [3:1] w_c;
            cla_lookahead4 u_la (
                .i_g   (w_g[j*GRP_W +: GRP_W]),
                .i_p   (w_p[j*GRP_W +: GRP_W]),
                .i_cin (w_gc[j]),
                .o_c   (w_c),
                .o_gg  (w_gg[j]),
                .o_pp  (w_pp[j])
            );
            assign w_cv[j*GRP_W +: GRP_W] = {w_c, w_gc[j]};
        end

        // Second level: group carries come straight from group G/P, no ripple.
        cla_lookahead4 u_la2 (
            .i_g   (w_gg),
            .i_p   (w_pp),
            .i_cin (w_cin[k]),
            .o_c   (w_gc_hi),
            .o_gg  (w_seg_g),
            .o_pp  (w_seg_p)
        );
        assign w_gc = {w_gc_hi, w_cin[k]};

        assign w_sum     = w_p ^ w_cv;
        assign w_cout[k] = w_seg_g | (w_seg_p & w_cin[k]);
        assign w_res[k]  = (w_lo[k] & ~(SEG_ONES << (k*SEG_W)))
                         | (WIDTH'(w_sum) << (k*SEG_W));

        if (k < NSEG-1) begin : g_reg
            logic             r_vld, r_sat, r_cy;
            logic [WIDTH-1:0] r_a, r_b, r_res;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld <= 1'b0;
                    r_sat <= 1'b0;
                    r_cy  <= 1'b0;
                    r_a   <= '0;
                    r_b   <= '0;
                    r_res <= '0;
                end else if (w_adv) begin
                    r_vld <= w_vld[k];
                    r_sat <= w_sat[k];
                    r_cy  <= w_cout[k];
                    r_a   <= w_a[k];
                    r_b   <= w_b[k];
                    r_res <= w_res[k];
                end
            end

            assign w_vld[k+1] = r_vld;
            assign w_sat[k+1] = r_sat;
            assign w_cin[k+1] = r_cy;
            assign w_a[k+1]   = r_a;
            assign w_b[k+1]   = r_b;
            assign w_lo[k+1]  = r_res;
        end
    end

    logic [WIDTH-1:0] w_raw, w_fin;
    logic             w_ovf;
    flags_t           w_flags;

    assign w_raw = w_res[NSEG-1];
    assign w_ovf = (w_a[NSEG-1][WIDTH-1] == w_b[NSEG-1][WIDTH-1])
                 & (w_raw[WIDTH-1] != w_a[NSEG-1][WIDTH-1]);

    // A wrapped-negative raw sum means positive overflow, so clamp to max.
    always_comb begin
        w_fin = w_raw;
        if (w_sat[NSEG-1] & w_ovf) begin
            w_fin = w_raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                   : {1'b1, {(WIDTH-1){1'b0}}};
        end
        w_flags.n = w_fin[WIDTH-1];
        w_flags.z = (w_fin == '0);
        w_flags.v = w_ovf;
        w_flags.c = w_cout[NSEG-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_flags <= '0;
        end else if (w_adv) begin
            r_out_valid <= w_vld[NSEG-1];
            r_out_sum   <= w_fin;
            r_out_flags <= w_flags;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_flags = r_out_flags;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub at WIDTH 16, 32 and 64 driven by one shared
// stimulus stream. Each width has its own reference: a delay line of NSEG
// slots filled from plain signed/unsigned arithmetic, checked every cycle.
module tb_cla_pipe_addsub;
    import cla_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        d_valid = 1'b0;
    logic        d_sub = 1'b0;
    logic        d_sat = 1'b0;
    logic        d_ordy = 1'b1;
    logic [63:0] d_a = '0;
    logic [63:0] d_b = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_w
        localparam int W = 16 << gi;
        localparam int L = W / 16;

        cla_pipe_addsub_if #(.WIDTH(W)) bus ();

        cla_pipe_addsub #(.WIDTH(W), .SAT_EN(1'b1)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.in_valid  = d_valid;
        assign bus.in_a      = d_a[W-1:0];
        assign bus.in_b      = d_b[W-1:0];
        assign bus.in_sub    = d_sub;
        assign bus.in_sat    = d_sat;
        assign bus.out_ready = d_ordy;

        function automatic void calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic sub, input logic sat,
                                     output logic [W-1:0] s, output logic [3:0] f);
            logic signed [W+1:0] sa, sb, r;
            logic [W:0]          u;
            logic                ovf, c;
            sa  = {{2{a[W-1]}}, a};
            sb  = {{2{b[W-1]}}, b};
            r   = sub ? (sa - sb) : (sa + sb);
            u   = {1'b0, a} + {1'b0, b};
            ovf = (r[W+1:W-1] != 3'b000) && (r[W+1:W-1] != 3'b111);
            c   = sub ? (a >= b) : u[W];
            s   = r[W-1:0];
            if (sat && ovf) s = r[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            f         = '0;
            f[FLAG_N] = s[W-1];
            f[FLAG_Z] = (s == '0);
            f[FLAG_V] = ovf;
            f[FLAG_C] = c;
        endfunction

        logic         m_v [L];
        logic [W-1:0] m_s [L];
        logic [3:0]   m_f [L];
        logic         m_adv;
        logic [W-1:0] c_s;
        logic [3:0]   c_f;

        assign m_adv = !m_v[L-1] || d_ordy;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < L; i++) begin
                    m_v[i] <= 1'b0;
                    m_s[i] <= '0;
                    m_f[i] <= '0;
                end
            end else if (m_adv) begin
                calc(d_a[W-1:0], d_b[W-1:0], d_sub, d_sat, c_s, c_f);
                m_v[0] <= d_valid;
                m_s[0] <= c_s;
                m_f[0] <= c_f;
                for (int i = 1; i < L; i++) begin
                    m_v[i] <= m_v[i-1];
                    m_s[i] <= m_s[i-1];
                    m_f[i] <= m_f[i-1];
                end
            end
        end

        always @(negedge clk) begin
            #1;
            if (!rst) begin
                n_cmp++;
                if (bus.out_valid !== m_v[L-1]) begin
                    n_err++;
                    $display("FAIL w%0d out_valid @%0t: got %b want %b", W, $time, bus.out_valid, m_v[L-1]);
                end
                n_cmp++;
                if (bus.in_ready !== m_adv) begin
                    n_err++;
                    $display("FAIL w%0d in_ready @%0t: got %b want %b", W, $time, bus.in_ready, m_adv);
                end
                if (m_v[L-1]) begin
                    n_cmp++;
                    if (bus.out_sum !== m_s[L-1]) begin
                        n_err++;
                        $display("FAIL w%0d out_sum @%0t: got %h want %h", W, $time, bus.out_sum, m_s[L-1]);
                    end
                    n_cmp++;
                    if (bus.out_flags !== m_f[L-1]) begin
                        n_err++;
                        $display("FAIL w%0d out_flags @%0t: got %b want %b", W, $time, bus.out_flags, m_f[L-1]);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Single beat through the 32-bit instance with literal expectations.
    task automatic run_one(input string nm, input logic [63:0] a, input logic [63:0] b,
                           input logic sub, input logic sat,
                           input logic [31:0] es, input logic [3:0] ef);
        int lat;
        @(negedge clk);
        d_valid = 1'b1; d_a = a; d_b = b; d_sub = sub; d_sat = sat; d_ordy = 1'b1;
        @(negedge clk);
        d_valid = 1'b0;
        lat = 1;
        while (!g_w[1].bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_valid"}, 64'(g_w[1].bus.out_valid), 64'd1);
        chk({nm, "_latency"}, 64'(lat), 64'd2);
        chk({nm, "_sum"}, 64'(g_w[1].bus.out_sum), 64'(es));
        chk({nm, "_flags"}, 64'(g_w[1].bus.out_flags), 64'(ef));
    endtask

    initial begin
        logic stale;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 64'(g_w[1].bus.out_valid), 64'd0);
        chk("rst_sum", 64'(g_w[1].bus.out_sum), 64'd0);
        chk("rst_flags", 64'(g_w[1].bus.out_flags), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_one("carry_seg", 64'h0000FFFF, 64'h00000001, 1'b0, 1'b0, 32'h00010000, 4'b0000);
        run_one("borrow",    64'h00000005, 64'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 4'b1000);
        run_one("sub_zero",  64'h00001234, 64'h00001234, 1'b1, 1'b0, 32'h00000000, 4'b0101);
        run_one("sat_pos",   64'h7FFFFFFF, 64'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 4'b0010);
        run_one("wrap_pos",  64'h7FFFFFFF, 64'h00000001, 1'b0, 1'b0, 32'h80000000, 4'b1010);
        run_one("sat_neg",   64'h80000000, 64'h00000001, 1'b1, 1'b1, 32'h80000000, 4'b1011);

        // Reset with two beats in flight.
        @(negedge clk);
        d_valid = 1'b1; d_a = 64'h11; d_b = 64'h22; d_sub = 1'b0; d_sat = 1'b0; d_ordy = 1'b1;
        @(negedge clk);
        d_a = 64'h33; d_b = 64'h44;
        @(negedge clk);
        d_valid = 1'b0;
        #1;
        chk("inflight_valid", 64'(g_w[1].bus.out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(g_w[1].bus.out_valid), 64'd0);
        chk("midrst_sum", 64'(g_w[1].bus.out_sum), 64'd0);
        chk("midrst_flags", 64'(g_w[1].bus.out_flags), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            stale = stale | g_w[0].bus.out_valid | g_w[1].bus.out_valid | g_w[2].bus.out_valid;
        end
        chk("no_stale_beat", 64'(stale), 64'd0);

        // Stream with a 4-cycle output stall in the middle.
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            d_valid = (c < 12);
            d_a     = {$urandom, $urandom};
            d_b     = {$urandom, $urandom};
            d_sub   = $urandom_range(0, 1);
            d_sat   = $urandom_range(0, 1);
            d_ordy  = !(c >= 5 && c < 9);
            if (c == 7) begin
                #1;
                chk("stall_in_ready", 64'(g_w[1].bus.in_ready), 64'd0);
                chk("stall_out_valid", 64'(g_w[1].bus.out_valid), 64'd1);
            end
        end

        // Long random run with random backpressure and corner operands.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            d_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       d_a = '0;
                1:       d_a = {32'h7FFFFFFF, 32'hFFFFFFFF};
                2:       d_a = {$urandom, 32'h7FFFFFFF};
                default: d_a = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 5))
                0:       d_b = 64'd1;
                1:       d_b = {32'h80000000, 32'h00000000};
                2:       d_b = d_a;
                default: d_b = {$urandom, $urandom};
            endcase
            d_sub  = $urandom_range(0, 1);
            d_sat  = $urandom_range(0, 1);
            d_ordy = ($urandom_range(0, 3) != 0);
        end

        @(negedge clk);
        d_valid = 1'b0;
        d_ordy  = 1'b1;
        repeat (8) @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
